// File: rtl/operand_read_pkg.sv
// Shared types and defaults for the operand read stage. The optional
// register-write bypass is enabled by defining READ_BYPASS_EN.
package operand_read_pkg;

  localparam int W  = 32;
  localparam int NR = 16;
  localparam int RB = $clog2(NR);

  typedef logic [W-1:0]     regval_t;
  typedef logic [RB-1:0]    regaddr_t;
  typedef regval_t [NR-1:0] regfile_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_L,
    LOAD_R,
    ISSUE
  } read_state_t;

endpackage

// File: rtl/operand_read_select.sv
// Operand value mux: register 0 reads as zero, an optional bypass overrides the
// register file (READ_BYPASS_EN), otherwise the indexed register entry is used.
module operand_select #(
  parameter  int W  = 32,
  parameter  int NR = 16,
  localparam int RB = $clog2(NR)
) (
  input  logic [NR*W-1:0] registers_i,
  input  logic [RB-1:0]   index_i,
`ifdef READ_BYPASS_EN
  input  logic            bypass_enable_i,
  input  logic [RB-1:0]   bypass_register_i,
  input  logic [W-1:0]    bypass_value_i,
`endif
  output logic [W-1:0]    value_o
);

  always_comb begin
    value_o = registers_i[index_i*W +: W];
`ifdef READ_BYPASS_EN
    if (bypass_enable_i && (bypass_register_i == index_i)) value_o = bypass_value_i;
`endif
    // Zero check comes last so neither the file nor the bypass can override r0.
    if (index_i == '0) value_o = '0;
  end

endmodule

// File: rtl/operand_read.sv
// Operand read stage: resolves register operands and fetches memory operands
// before handing the instruction to execute. Bypass ports exist with READ_BYPASS_EN.
module operand_read #(
  parameter  int W   = operand_read_pkg::W,
  parameter  int NR  = operand_read_pkg::NR,
  parameter  int OPW = 8,
  localparam int RB  = $clog2(NR)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NR*W-1:0] registers,
  output logic            address_enable,
  output logic [W-1:0]    address,
  input  logic            data_valid,
  input  logic [W-1:0]    data,
  input  logic [W-1:0]    in_pc,
  input  logic [W-1:0]    in_adjustment,
  input  logic [RB-1:0]   in_destination,
  input  logic [RB-1:0]   in_left_register,
  input  logic [RB-1:0]   in_right_register,
  input  logic [OPW-1:0]  in_operation,
  input  logic [OPW-1:0]  in_adjustment_operation,
  input  logic            in_left_is_memory,
  input  logic            in_right_is_memory,
  input  logic            in_destination_is_memory,
  input  logic            in_has_flushed,
  input  logic            in_is_valid,
  output logic            in_hold,
  output logic [W-1:0]    out_pc,
  output logic [W-1:0]    out_adjustment,
  output logic [W-1:0]    out_left_value,
  output logic [W-1:0]    out_right_value,
  output logic [RB-1:0]   out_destination,
  output logic [OPW-1:0]  out_operation,
  output logic [OPW-1:0]  out_adjustment_operation,
  output logic            out_destination_is_memory,
  output logic            out_has_flushed,
  output logic            out_is_valid,
`ifdef READ_BYPASS_EN
  input  logic            bypass_enable,
  input  logic [RB-1:0]   bypass_register,
  input  logic [W-1:0]    bypass_value,
`endif
  input  logic            out_hold
);

  import operand_read_pkg::*;

  typedef struct packed {
    logic [W-1:0]   pc;
    logic [W-1:0]   adjustment;
    logic [W-1:0]   left_value;
    logic [W-1:0]   right_value;
    logic [RB-1:0]  destination;
    logic [OPW-1:0] operation;
    logic [OPW-1:0] adjustment_operation;
    logic           destination_is_memory;
    logic           has_flushed;
    logic           is_valid;
  } bundle_t;

  read_state_t  state_q, state_d;
  bundle_t      out_q, out_d, cap_q, cap_d, in_bundle;
  logic         cap_right_mem_q, cap_right_mem_d;
  logic         addr_en_q, addr_en_d;
  logic [W-1:0] addr_q, addr_d;
  logic [W-1:0] left_val, right_val;
  logic         any_memory, mem_ack;

  operand_select #(.W(W), .NR(NR)) u_left_sel (
    .registers_i       (registers),
    .index_i           (in_left_register),
`ifdef READ_BYPASS_EN
    .bypass_enable_i   (bypass_enable),
    .bypass_register_i (bypass_register),
    .bypass_value_i    (bypass_value),
`endif
    .value_o           (left_val)
  );

  operand_select #(.W(W), .NR(NR)) u_right_sel (
    .registers_i       (registers),
    .index_i           (in_right_register),
`ifdef READ_BYPASS_EN
    .bypass_enable_i   (bypass_enable),
    .bypass_register_i (bypass_register),
    .bypass_value_i    (bypass_value),
`endif
    .value_o           (right_val)
  );

  assign any_memory = in_left_is_memory | in_right_is_memory;
  assign mem_ack    = addr_en_q & data_valid;

  always_comb begin
    in_bundle.pc                    = in_pc;
    in_bundle.adjustment            = in_adjustment;
    in_bundle.left_value            = left_val;
    in_bundle.right_value           = right_val;
    in_bundle.destination           = in_destination;
    in_bundle.operation             = in_operation;
    in_bundle.adjustment_operation  = in_adjustment_operation;
    in_bundle.destination_is_memory = in_destination_is_memory;
    in_bundle.has_flushed           = in_has_flushed;
    in_bundle.is_valid              = in_is_valid;
  end

  // NOTE: every signal written here gets its hold value first; a path that
  // left one unassigned would infer a latch instead of combinational logic.
  always_comb begin
    state_d         = state_q;
    out_d           = out_q;
    cap_d           = cap_q;
    cap_right_mem_d = cap_right_mem_q;
    addr_en_d       = addr_en_q;
    addr_d          = addr_q;
    unique case (state_q)
      IDLE: if (!out_hold) begin
        if (in_is_valid && any_memory) begin
          // Register operands are frozen here; memory operands overwrite them later.
          cap_d           = in_bundle;
          cap_right_mem_d = in_right_is_memory;
          out_d.is_valid  = 1'b0;
          addr_en_d       = 1'b1;
          addr_d          = in_left_is_memory ? left_val : right_val;
          state_d         = in_left_is_memory ? LOAD_L : LOAD_R;
        end else begin
          out_d = in_bundle;
        end
      end
      LOAD_L: if (mem_ack) begin
        cap_d.left_value = data;
        if (cap_right_mem_q) begin
          addr_d  = cap_q.right_value;
          state_d = LOAD_R;
        end else begin
          addr_en_d = 1'b0;
          state_d   = ISSUE;
        end
      end
      LOAD_R: if (mem_ack) begin
        cap_d.right_value = data;
        addr_en_d         = 1'b0;
        state_d           = ISSUE;
      end
      ISSUE: if (!out_hold) begin
        out_d          = cap_q;
        out_d.is_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      out_q           <= '0;
      cap_q           <= '0;
      cap_right_mem_q <= 1'b0;
      addr_en_q       <= 1'b0;
      addr_q          <= '0;
    end else begin
      state_q         <= state_d;
      out_q           <= out_d;
      cap_q           <= cap_d;
      cap_right_mem_q <= cap_right_mem_d;
      addr_en_q       <= addr_en_d;
      addr_q          <= addr_d;
    end
  end

  assign in_hold = out_hold | (reset_n & (state_q != IDLE));

  assign address_enable            = addr_en_q;
  assign address                   = addr_q;
  assign out_pc                    = out_q.pc;
  assign out_adjustment            = out_q.adjustment;
  assign out_left_value            = out_q.left_value;
  assign out_right_value           = out_q.right_value;
  assign out_destination           = out_q.destination;
  assign out_operation             = out_q.operation;
  assign out_adjustment_operation  = out_q.adjustment_operation;
  assign out_destination_is_memory = out_q.destination_is_memory;
  assign out_has_flushed           = out_q.has_flushed;
  assign out_is_valid              = out_q.is_valid;

endmodule

// File: tb/tb_operand_read.sv
// Self-checking bench for operand_read: vector table, directed multi-cycle
// sequences and randomized instructions against a behavioural model.
module tb_operand_read;

  localparam int W   = 32;
  localparam int NR  = 16;
  localparam int OPW = 8;
  localparam int RB  = 4;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [NR*W-1:0] registers;
  logic [W-1:0]    rf [NR];
  logic            address_enable, data_valid, in_hold, out_hold;
  logic [W-1:0]    address, data;
  logic [W-1:0]    in_pc, in_adjustment;
  logic [RB-1:0]   in_destination, in_left_register, in_right_register;
  logic [OPW-1:0]  in_operation, in_adjustment_operation;
  logic            in_left_is_memory, in_right_is_memory, in_destination_is_memory;
  logic            in_has_flushed, in_is_valid;
  logic [W-1:0]    out_pc, out_adjustment, out_left_value, out_right_value;
  logic [RB-1:0]   out_destination;
  logic [OPW-1:0]  out_operation, out_adjustment_operation;
  logic            out_destination_is_memory, out_has_flushed, out_is_valid;
`ifdef READ_BYPASS_EN
  logic            bypass_enable;
  logic [RB-1:0]   bypass_register;
  logic [W-1:0]    bypass_value;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]   pc, adj;
    logic [RB-1:0]  dest, lreg, rreg;
    logic [OPW-1:0] op, adjop;
    logic           lmem, rmem, dmem, flushed, valid;
  } instr_t;

  typedef struct {
    logic [W-1:0]   pc, adj, left, right;
    logic [RB-1:0]  dest;
    logic [OPW-1:0] op, adjop;
    logic           dmem, flushed, valid;
  } exp_t;

  typedef struct {
    logic [RB-1:0] lreg, rreg;
    logic          valid;
    logic [W-1:0]  exp_l, exp_r;
    logic          exp_valid;
  } vec_t;

  operand_read #(.W(W), .NR(NR), .OPW(OPW)) dut (
    .clock                     (clock),
    .reset_n                   (reset_n),
    .registers                 (registers),
    .address_enable            (address_enable),
    .address                   (address),
    .data_valid                (data_valid),
    .data                      (data),
    .in_pc                     (in_pc),
    .in_adjustment             (in_adjustment),
    .in_destination            (in_destination),
    .in_left_register          (in_left_register),
    .in_right_register         (in_right_register),
    .in_operation              (in_operation),
    .in_adjustment_operation   (in_adjustment_operation),
    .in_left_is_memory         (in_left_is_memory),
    .in_right_is_memory        (in_right_is_memory),
    .in_destination_is_memory  (in_destination_is_memory),
    .in_has_flushed            (in_has_flushed),
    .in_is_valid               (in_is_valid),
    .in_hold                   (in_hold),
    .out_pc                    (out_pc),
    .out_adjustment            (out_adjustment),
    .out_left_value            (out_left_value),
    .out_right_value           (out_right_value),
    .out_destination           (out_destination),
    .out_operation             (out_operation),
    .out_adjustment_operation  (out_adjustment_operation),
    .out_destination_is_memory (out_destination_is_memory),
    .out_has_flushed           (out_has_flushed),
    .out_is_valid              (out_is_valid),
`ifdef READ_BYPASS_EN
    .bypass_enable             (bypass_enable),
    .bypass_register           (bypass_register),
    .bypass_value              (bypass_value),
`endif
    .out_hold                  (out_hold)
  );

  always #5 clock = ~clock;

  always_comb begin
    registers = '0;
    for (int i = 0; i < NR; i++) registers[i*W +: W] = rf[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] reg_value(input logic [RB-1:0] idx);
    return (idx == 0) ? '0 : rf[idx];
  endfunction

  // Expected outputs: memory operands come from the responses, the rest from the file.
  function automatic exp_t model(input instr_t i, input logic [W-1:0] dl, input logic [W-1:0] dr);
    exp_t e;
    e.pc      = i.pc;
    e.adj     = i.adj;
    e.dest    = i.dest;
    e.op      = i.op;
    e.adjop   = i.adjop;
    e.dmem    = i.dmem;
    e.flushed = i.flushed;
    e.valid   = i.valid;
    e.left    = i.lmem ? dl : reg_value(i.lreg);
    e.right   = i.rmem ? dr : reg_value(i.rreg);
    return e;
  endfunction

  task automatic apply(input instr_t i);
    in_pc                    = i.pc;
    in_adjustment            = i.adj;
    in_destination           = i.dest;
    in_left_register         = i.lreg;
    in_right_register        = i.rreg;
    in_operation             = i.op;
    in_adjustment_operation  = i.adjop;
    in_left_is_memory        = i.lmem;
    in_right_is_memory       = i.rmem;
    in_destination_is_memory = i.dmem;
    in_has_flushed           = i.flushed;
    in_is_valid              = i.valid;
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check({tag, "_pc"},      out_pc, e.pc);
    check({tag, "_adj"},     out_adjustment, e.adj);
    check({tag, "_left"},    out_left_value, e.left);
    check({tag, "_right"},   out_right_value, e.right);
    check({tag, "_dest"},    out_destination, e.dest);
    check({tag, "_op"},      out_operation, e.op);
    check({tag, "_adjop"},   out_adjustment_operation, e.adjop);
    check({tag, "_dmem"},    out_destination_is_memory, e.dmem);
    check({tag, "_flushed"}, out_has_flushed, e.flushed);
    check({tag, "_valid"},   out_is_valid, e.valid);
  endtask

  function automatic instr_t mk(input logic [RB-1:0] l, input logic [RB-1:0] r,
                                input logic lm, input logic rm, input logic [W-1:0] pc);
    instr_t i;
    i.pc = pc; i.adj = pc ^ 32'h0000_00FF; i.dest = l ^ r; i.lreg = l; i.rreg = r;
    i.op = pc[7:0]; i.adjop = ~pc[7:0]; i.lmem = lm; i.rmem = rm;
    i.dmem = pc[0]; i.flushed = pc[1]; i.valid = 1'b1;
    return i;
  endfunction

  // One memory operand transfer with a random response delay.
  task automatic serve(input string tag, input logic [W-1:0] addr, input logic [W-1:0] val);
    int d = $urandom_range(0, 3);
    for (int c = 0; c < d; c++) begin
      check({tag, "_wait_en"}, address_enable, 1'b1);
      check({tag, "_wait_addr"}, address, addr);
      data = $urandom;
      tick();
    end
    check({tag, "_en"}, address_enable, 1'b1);
    check({tag, "_addr"}, address, addr);
    check({tag, "_hold"}, in_hold, 1'b1);
    data       = val;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_hold && n < 20) begin
      tick();
      n++;
    end
    if (in_hold) begin
      checks++;
      errors++;
      $display("FAIL wait_ready timeout actual=in_hold=1 expected=0");
    end
  endtask

  initial begin
    vec_t   vecs[5];
    instr_t ins;
    exp_t   e;

    reset_n = 1'b0; out_hold = 1'b0; data_valid = 1'b0; data = '0;
    ins = mk(0, 0, 0, 0, 0);
    ins.valid = 1'b0;
    apply(ins);
`ifdef READ_BYPASS_EN
    bypass_enable = 1'b0; bypass_register = '0; bypass_value = '0;
`endif
    for (int i = 0; i < NR; i++) rf[i] = W'(i) << 4;

    tick(); tick();
    check("rst_in_hold", in_hold, 1'b0);
    check("rst_addr_en", address_enable, 1'b0);
    check("rst_addr", address, '0);
    check("rst_valid", out_is_valid, 1'b0);
    check("rst_left", out_left_value, '0);
    check("rst_pc", out_pc, '0);
    reset_n = 1'b1;

    // Single-cycle register-only instructions.
    vecs[0] = '{lreg: 1,  rreg: 2,  valid: 1, exp_l: 32'h10, exp_r: 32'h20, exp_valid: 1};
    vecs[1] = '{lreg: 0,  rreg: 15, valid: 1, exp_l: 32'h00, exp_r: 32'hF0, exp_valid: 1};
    vecs[2] = '{lreg: 15, rreg: 0,  valid: 1, exp_l: 32'hF0, exp_r: 32'h00, exp_valid: 1};
    vecs[3] = '{lreg: 7,  rreg: 7,  valid: 0, exp_l: 32'h70, exp_r: 32'h70, exp_valid: 0};
    vecs[4] = '{lreg: 3,  rreg: 0,  valid: 1, exp_l: 32'h30, exp_r: 32'h00, exp_valid: 1};
    for (int k = 0; k < 5; k++) begin
      ins = mk(vecs[k].lreg, vecs[k].rreg, 0, 0, 32'h1000 + 32'(k) * 32'h13);
      ins.valid = vecs[k].valid;
      apply(ins);
      tick();
      check($sformatf("vec%0d_left", k), out_left_value, vecs[k].exp_l);
      check($sformatf("vec%0d_right", k), out_right_value, vecs[k].exp_r);
      check($sformatf("vec%0d_valid", k), out_is_valid, vecs[k].exp_valid);
      check($sformatf("vec%0d_pc", k), out_pc, ins.pc);
      check($sformatf("vec%0d_adjop", k), out_adjustment_operation, ins.adjop);
      check($sformatf("vec%0d_addr_en", k), address_enable, 1'b0);
      check($sformatf("vec%0d_in_hold", k), in_hold, 1'b0);
    end

    // Right operand from memory, response on the third cycle of the load.
    apply(mk(1, 2, 0, 1, 32'h200));
    tick();
    in_is_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check("rmem_addr", address, 32'h20);
      check("rmem_en", address_enable, 1'b1);
      check("rmem_hold", in_hold, 1'b1);
      tick();
    end
    check("rmem_addr3", address, 32'h20);
    data_valid = 1'b1; data = 32'hCAFE;
    tick();
    data_valid = 1'b0;
    check("rmem_issue_en", address_enable, 1'b0);
    check("rmem_issue_hold", in_hold, 1'b1);
    tick();
    check("rmem_right", out_right_value, 32'hCAFE);
    check("rmem_left", out_left_value, 32'h10);
    check("rmem_valid", out_is_valid, 1'b1);
    check("rmem_idle_hold", in_hold, 1'b0);

    // Both operands from memory: back-to-back addresses.
    apply(mk(1, 2, 1, 1, 32'h300));
    tick();
    in_is_valid = 1'b0;
    check("both_addr_l", address, 32'h10);
    data_valid = 1'b1; data = 32'hA;
    tick();
    check("both_addr_r", address, 32'h20);
    check("both_en_r", address_enable, 1'b1);
    data = 32'hB;
    tick();
    data_valid = 1'b0;
    check("both_en_off", address_enable, 1'b0);
    tick();
    check("both_left", out_left_value, 32'hA);
    check("both_right", out_right_value, 32'hB);
    check("both_valid", out_is_valid, 1'b1);

    // Execute stall while in ISSUE.
    apply(mk(2, 1, 0, 0, 32'h500));
    tick();
    apply(mk(3, 4, 0, 1, 32'h600));
    tick();
    in_is_valid = 1'b0;
    check("stall_addr", address, 32'h40);
    data_valid = 1'b1; data = 32'h1234;
    tick();
    data_valid = 1'b0;
    out_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("stall_in_hold", in_hold, 1'b1);
      check("stall_left", out_left_value, 32'h20);
      check("stall_right", out_right_value, 32'h10);
      check("stall_pc", out_pc, 32'h500);
      tick();
    end
    out_hold = 1'b0;
    tick();
    check("stall_rel_left", out_left_value, 32'h30);
    check("stall_rel_right", out_right_value, 32'h1234);
    check("stall_rel_pc", out_pc, 32'h600);
    check("stall_rel_valid", out_is_valid, 1'b1);
    check("stall_rel_hold", in_hold, 1'b0);
    tick();
    check("stall_idle_valid", out_is_valid, 1'b0);

`ifdef READ_BYPASS_EN
    bypass_enable = 1'b1; bypass_register = 1; bypass_value = 32'h99;
    apply(mk(1, 2, 0, 0, 32'h700));
    tick();
    check("byp_left", out_left_value, 32'h99);
    check("byp_right", out_right_value, 32'h20);
    bypass_register = 0;
    apply(mk(0, 0, 0, 0, 32'h704));
    tick();
    check("byp_r0", out_left_value, '0);
    bypass_enable = 1'b0;
`endif

    // Randomized instructions against the model.
    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] dl, dr, al, ar;
      string tag;
      tag = $sformatf("rnd%0d", t);
      for (int i = 0; i < NR; i++) rf[i] = $urandom;
      ins = mk(RB'($urandom), RB'($urandom), 1'($urandom), 1'($urandom), $urandom);
      dl = $urandom; dr = $urandom;
      al = reg_value(ins.lreg); ar = reg_value(ins.rreg);
      e  = model(ins, dl, dr);
      wait_ready();
      apply(ins);
      tick();
      in_is_valid = 1'b0;
      if (!(ins.lmem || ins.rmem)) begin
        check_out(tag, e);
      end else begin
        // Operands already captured must ignore later register-file writes.
        if (!(ins.lmem && ins.rmem))
          for (int i = 0; i < NR; i++) rf[i] = $urandom;
        if (ins.lmem) serve({tag, "_l"}, al, dl);
        if (ins.rmem) serve({tag, "_r"}, ar, dr);
        check({tag, "_issue_en"}, address_enable, 1'b0);
        out_hold = 1'b1;
        for (int c = 0; c < int'($urandom_range(0, 2)); c++) begin
          data_valid = 1'b1;
          data       = $urandom;
          check({tag, "_issue_hold"}, in_hold, 1'b1);
          tick();
        end
        out_hold   = 1'b0;
        data_valid = 1'b0;
        tick();
        check_out(tag, e);
      end
      check({tag, "_ready"}, in_hold, 1'b0);
    end

    // Reset in the middle of LOAD_R abandons the load.
    for (int i = 0; i < NR; i++) rf[i] = W'(i) << 4;
    apply(mk(1, 2, 1, 1, 32'h800));
    tick();
    in_is_valid = 1'b0;
    data_valid = 1'b1; data = 32'h77;
    tick();
    data_valid = 1'b0;
    check("mid_addr_r", address, 32'h20);
    check("mid_en_r", address_enable, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_in_hold_comb", in_hold, 1'b0);
    tick(); tick();
    check("mid_rst_en", address_enable, 1'b0);
    check("mid_rst_addr", address, '0);
    check("mid_rst_valid", out_is_valid, 1'b0);
    check("mid_rst_left", out_left_value, '0);
    check("mid_rst_in_hold", in_hold, 1'b0);
    reset_n = 1'b1;
    tick();
    check("mid_post_in_hold", in_hold, 1'b0);
    check("mid_post_en", address_enable, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
